complex_requant_fifo: RTL and testbench

COMPLEX_REQUANT_FIFO -- requirements
Module: complex_requant_fifo

---
 rtl/complex_requant_fifo.sv | 140 ++++++++++++++
 tb/tb_complex_requant_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_requant_fifo.sv
// complex_requant_fifo
// Requantizes a complex word (cr, ci) from WL_out to WL bits on entry. Each
// component is either halved with round-half-up or passed through, and then
// saturated to WL bits. The {sat, dr, di} result is stored in a small FIFO.
// The head of the FIFO is held in its own register, so dr/di/sat/out_valid
// and in_ready all come straight from flops. The block also keeps a
// saturating count of accepted words that had sat set.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready.
// The head word is popped on a rising edge where out_valid && out_ready.
// in_ready is a registered "occupancy < DEPTH" flag and does not look at
// out_ready in the same cycle, so a full FIFO never accepts a word, even
// when a pop happens in that cycle. out_ready is ignored while out_valid=0.
// in_valid is ignored while in_ready=0.
module complex_requant_fifo #(
  parameter int WL     = 14,
  parameter int WL_out = WL + 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WL_out-1:0] cr,
  input  logic [WL_out-1:0] ci,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              scale,
  output logic [WL-1:0]     dr,
  output logic [WL-1:0]     di,
  output logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        sat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * WL + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Quantizer limits, computed in WL_out+1 bits.
  localparam logic signed [WL_out:0] MAX_V = {{(WL_out-WL+2){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [WL_out:0] MIN_V = {{(WL_out-WL+2){1'b1}}, {(WL-1){1'b0}}};
  localparam logic signed [WL_out:0] RND_V = {{WL_out{1'b0}}, 1'b1};

  // Returns {saturated, y[WL-1:0]} for a single component.
  function automatic logic [WL:0] quant(input logic [WL_out-1:0] x, input logic sc);
    logic signed [WL_out:0] xe;
    logic signed [WL_out:0] t;
    logic                   s;
    logic [WL-1:0]          y;
    xe = $signed({x[WL_out-1], x});
    if (sc) t = (xe + RND_V) >>> 1;
    else    t = xe;
    s = 1'b0;
    y = t[WL-1:0];
    if (t > MAX_V) begin
      s = 1'b1;
      y = MAX_V[WL-1:0];
    end else if (t < MIN_V) begin
      s = 1'b1;
      y = MIN_V[WL-1:0];
    end
    return {s, y};
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0] count, count_next;
  logic [EW-1:0] head, head_next;
  logic          in_ready_r, out_valid_r;
  logic [7:0]    sat_cnt_r;
  logic [WL:0]   q_re, q_im;
  logic [EW-1:0] new_word;
  logic          push, pop;

  assign push       = in_valid & in_ready_r & ~reset;
  assign pop        = out_valid_r & out_ready & ~reset;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // Quantize both components of the incoming word and merge their saturation flags.
  always_comb begin
    q_re     = quant(cr, scale);
    q_im     = quant(ci, scale);
    new_word = {q_re[WL] | q_im[WL], q_re[WL-1:0], q_im[WL-1:0]};
  end

  // Compute the next occupancy and the next head word from this cycle's push and pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
    head_next = head;
    if (pop) begin
      if (count > ONE_C)  head_next = mem[rd_ptr_inc];
      else if (push)      head_next = new_word;
    end else if ((count == '0) && push) begin
      head_next = new_word;
    end
  end

  // Storage array; this array is not reset because the pointers and occupancy define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_word;
  end

  // Control state: pointers, occupancy, registered flags, head register and saturation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      head        <= '0;
      sat_cnt_r   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count       <= count_next;
      in_ready_r  <= (count_next < DEPTH_C);
      out_valid_r <= (count_next != '0);
      head        <= head_next;
      if (push && new_word[EW-1] && (sat_cnt_r != 8'hFF))
        sat_cnt_r <= sat_cnt_r + 8'd1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sat       = head[EW-1];
  assign dr        = head[2*WL-1:WL];
  assign di        = head[WL-1:0];
  assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_complex_requant_fifo.sv
// tb_complex_requant_fifo
// Table-driven quantizer vectors plus hand-written FIFO sequences. A
// scoreboard queue models the FIFO contents and the saturation counter.
module tb_complex_requant_fifo;

  localparam int WL    = 14;
  localparam int WLO   = WL + 1;
  localparam int DEPTH = 4;
  localparam int W     = 2 * WL + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [WLO-1:0] cr, ci;
  logic           in_valid, in_ready, scale;
  logic [WL-1:0]  dr, di;
  logic           sat, out_valid, out_ready;
  logic [7:0]     sat_cnt;

  complex_requant_fifo #(.WL(WL), .WL_out(WLO), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cr(cr), .ci(ci), .in_valid(in_valid),
    .in_ready(in_ready), .scale(scale), .dr(dr), .di(di), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sat_cnt(sat_cnt)
  );

  // Clock and reset defaults
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  int exp_cnt = 0;
  int drv_cr, drv_ci;
  bit drv_sc;

  typedef struct {
    int cr; int ci; bit sc;
    int dr; int di; bit sat;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quantizer: returns {sat, y} with y as a 32-bit value.
  function automatic logic [32:0] quant_ref(input int x, input bit sc);
    int v;
    bit s;
    int maxv;
    int minv;
    maxv = (1 << (WL - 1)) - 1;
    minv = -(1 << (WL - 1));
    v = x;
    if (sc) begin
      v = x + 1;
      if (v >= 0) v = v / 2;
      else        v = -((1 - v) / 2);
    end
    s = 1'b0;
    if (v > maxv) begin v = maxv; s = 1'b1; end
    if (v < minv) begin v = minv; s = 1'b1; end
    return {s, 32'(v)};
  endfunction

  function automatic logic [W-1:0] pack_exp(input int r, input int i, input bit s);
    logic [31:0] a, b;
    a = 32'(r);
    b = 32'(i);
    return {s, a[WL-1:0], b[WL-1:0]};
  endfunction

  function automatic logic [W-1:0] model(input int r, input int i, input bit sc);
    logic [32:0] qr, qi;
    qr = quant_ref(r, sc);
    qi = quant_ref(i, sc);
    return {qr[32] | qi[32], qr[WL-1:0], qi[WL-1:0]};
  endfunction

  // Driver: put a word on the input bus
  task automatic drive(input int r, input int i, input bit sc, input bit v);
    drv_cr   = r;
    drv_ci   = i;
    drv_sc   = sc;
    cr       = WLO'(r);
    ci       = WLO'(i);
    scale    = sc;
    in_valid = v;
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, (1 << WLO) - 1)) - (1 << (WLO - 1));
  endfunction

  // One cycle: check outputs against the scoreboard, book push/pop, advance to the next negedge.
  task automatic step(input bit use_tbl, input logic [W-1:0] tbl_e);
    logic [W-1:0] e;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
    if (out_valid && exp_q.size() != 0) begin
      check("head", 64'({sat, dr, di}), 64'(exp_q[0]));
      if (out_ready) void'(exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      e = use_tbl ? tbl_e : model(drv_cr, drv_ci, drv_sc);
      exp_q.push_back(e);
      if (e[W-1] && exp_cnt < 255) exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_dr", 64'(dr), 64'(0));
    check("rst_di", 64'(di), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    exp_q.delete();
    exp_cnt  = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step(1'b0, '0);
    check("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int  n_acc;
    bit  acc;
    tbl[0]  = '{5, -5, 1'b1, 3, -2, 1'b0};
    tbl[1]  = '{16383, -16384, 1'b1, 8191, -8192, 1'b1};
    tbl[2]  = '{9000, -100, 1'b0, 8191, -100, 1'b1};
    tbl[3]  = '{-9000, 0, 1'b0, -8192, 0, 1'b1};
    tbl[4]  = '{8191, -8192, 1'b0, 8191, -8192, 1'b0};
    tbl[5]  = '{8192, -8193, 1'b0, 8191, -8192, 1'b1};
    tbl[6]  = '{16382, -16383, 1'b1, 8191, -8191, 1'b0};
    tbl[7]  = '{-1, 1, 1'b1, 0, 1, 1'b0};
    tbl[8]  = '{-2, -3, 1'b1, -1, -1, 1'b0};
    tbl[9]  = '{7, -7, 1'b0, 7, -7, 1'b0};
    tbl[10] = '{0, 0, 1'b1, 0, 0, 1'b0};
    tbl[11] = '{100, 16381, 1'b1, 50, 8191, 1'b0};

    reset = 1'b1; out_ready = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    do_reset();

    // Quantizer table, streamed with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].cr, tbl[k].ci, tbl[k].sc, 1'b1);
      step(1'b1, pack_exp(tbl[k].dr, tbl[k].di, tbl[k].sat));
    end
    drain(10);
    check("sat_cnt_after_tbl", 64'(sat_cnt), 64'(4));

    // Fill to full with out_ready low; the 5th word must wait
    out_ready = 1'b0;
    n_acc = 0;
    acc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (acc) drive(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
      acc = in_ready;
      step(1'b0, '0);
      if (acc) n_acc++;
    end
    check("accepts_at_full", 64'(n_acc), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    // Pop at full while in_valid is high: no push that cycle
    out_ready = 1'b1;
    step(1'b0, '0);
    check("after_full_pop_in_ready", 64'(in_ready), 64'(1));
    drain(10);

    // Steady push+pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
      step(1'b0, '0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
      step(1'b0, '0);
    end
    drain(10);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'b0, '0);
    end
    drain(10);

    // Saturation counter must stop at 255
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      drive((k % 2 == 0) ? 16383 : -16384, 0, 1'b0, 1'b1);
      step(1'b0, '0);
    end
    check("sat_cnt_ceiling", 64'(sat_cnt), 64'(255));
    drain(10);

    // Three words stored, then reset mid-stream with traffic active
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(9000 + k, -9000, 1'b0, 1'b1);
      step(1'b0, '0);
    end
    check("pre_rst_sat_cnt", 64'(sat_cnt), 64'(255));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    do_reset();

    // Fresh word after reset must come out alone, with no stale data
    out_ready = 1'b1;
    drive(5, -5, 1'b1, 1'b1);
    step(1'b0, '0);
    drive(0, 0, 1'b0, 1'b0);
    step(1'b0, '0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
